// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor, one CHUNK of the operands per stage.
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  logic             w_adv;
  logic [WIDTH-1:0] w_ao [STAGES];
  logic [WIDTH-1:0] w_bo [STAGES];
  logic [WIDTH-1:0] w_so [STAGES];
  logic             w_cq [STAGES];
  logic             w_vq [STAGES];
`ifdef PIPE_ADDER_OVF_EN
  logic             w_ovf;
`endif

  assign w_adv     = !w_vq[STAGES-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = w_vq[STAGES-1];
  assign sum       = w_so[STAGES-1];
  assign cout      = w_cq[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
  assign ovf       = w_ovf;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [WIDTH-1:0] w_ai;
    logic [WIDTH-1:0] w_bi;
    logic [WIDTH-1:0] w_si;
    logic [WIDTH-1:0] w_res;
    logic             w_ci;
    logic             w_vi;
    logic [CHUNK-1:0] w_sc;
    logic             w_co;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_s;
    logic             r_c;
    logic             r_v;

    // B is inverted once on entry, so sub only
    // has to steer the stage-0 carry-in.
    if (k == 0) begin : g_head
      assign w_ai = a;
      assign w_bi = b ^ {WIDTH{sub}};
      assign w_si = '0;
      assign w_ci = sub | cin;
      assign w_vi = in_valid;
    end else begin : g_body
      assign w_ai = w_ao[k-1];
      assign w_bi = w_bo[k-1];
      assign w_si = w_so[k-1];
      assign w_ci = w_cq[k-1];
      assign w_vi = w_vq[k-1];
    end

    assign {w_co, w_sc} =
      {1'b0, w_ai[k*CHUNK +: CHUNK]} +
      {1'b0, w_bi[k*CHUNK +: CHUNK]} +
      {{CHUNK{1'b0}}, w_ci};

    // Merge this stage's chunk into the partial result.
    always_comb begin
      w_res = w_si;
      w_res[k*CHUNK +: CHUNK] = w_sc;
    end

    // Stage register: operands, partial sum, carry, valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_a <= '0;
        r_b <= '0;
        r_s <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_adv) begin
        r_a <= w_ai;
        r_b <= w_bi;
        r_s <= w_res;
        r_c <= w_co;
        r_v <= w_vi;
      end
    end

    assign w_ao[k] = r_a;
    assign w_bo[k] = r_b;
    assign w_so[k] = r_s;
    assign w_cq[k] = r_c;
    assign w_vq[k] = r_v;

`ifdef PIPE_ADDER_OVF_EN
    if (k == STAGES-1) begin : g_ovf
      logic w_cmsb;
      logic r_ovf;

      assign w_cmsb = w_ai[WIDTH-1] ^
                      w_bi[WIDTH-1] ^
                      w_sc[CHUNK-1];

      // Overflow flag, aligned with the last stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_cmsb ^ w_co;
        end
      end

      assign w_ovf = r_ovf;
    end
`endif
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed and streamed checks for pipelined_adder.
// Main instance STAGES=4, plus STAGES=1 and STAGES=8.
module tb_pipelined_adder;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;

  logic        in_ready, out_valid, cout;
  logic [31:0] sum;
  logic        in_ready1, out_valid1, cout1;
  logic [31:0] sum1;
  logic        in_ready8, out_valid8, cout8;
  logic [31:0] sum8;
`ifdef PIPE_ADDER_OVF_EN
  logic        ovf, ovf1, ovf8;
`endif

  int nvec = 0;
  int nerr = 0;

  vec_t tbl [14];
  vec_t inq [$];
  vec_t expq [$];

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  pipelined_adder #(.WIDTH(32), .STAGES(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  pipelined_adder #(.WIDTH(32), .STAGES(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready8),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid8), .out_ready(out_ready),
    .sum(sum8), .cout(cout8)
`ifdef PIPE_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] xa,
                              input logic [31:0] xb,
                              input logic xc,
                              input logic xs);
    vec_t v;
    logic [32:0] t;
    logic [31:0] bb;
    bb = xs ? ~xb : xb;
    t = {1'b0, xa} + {1'b0, bb} + {32'd0, (xs ? 1'b1 : xc)};
    v.a = xa; v.b = xb; v.cin = xc; v.sub = xs;
    v.s = t[31:0];
    v.co = t[32];
    v.ov = (xa[31] == bb[31]) && (t[31] != xa[31]);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
  endtask

  task automatic check_out(input string nm, input vec_t e);
    chk({nm, "_sum"}, sum, e.s);
    chk({nm, "_cout"}, cout, e.co);
`ifdef PIPE_ADDER_OVF_EN
    chk({nm, "_ovf"}, ovf, e.ov);
`endif
  endtask

  // One isolated op on the main instance; checks latency too.
  task automatic single(input vec_t v);
    int cnt;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    drive(v);
    #1 chk("single_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("latency", cnt, 4);
    check_out("single", v);
  endtask

  // mode 0: free flow, 1: back-pressure, 2: random.
  task automatic run_stream(input int mode, input int budget);
    int cyc;
    bit want;
    bit saw_full;
    vec_t e;
    cyc = 0;
    saw_full = 0;
    while ((inq.size() > 0 || expq.size() > 0) && cyc < budget) begin
      @(negedge clk);
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (cyc < 2) || (cyc >= 14);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      want = (inq.size() > 0) &&
             (mode != 2 || $urandom_range(0, 3) != 0);
      in_valid = want;
      if (want) drive(inq[0]);
      #1;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          e = expq.pop_front();
          check_out("stream", e);
        end
      end else if (out_valid && mode == 1 && expq.size() > 0) begin
        chk("held_sum", sum, expq[0].s);
      end
      if (mode == 1 && !out_ready && expq.size() >= 4) begin
        saw_full = 1;
        chk("full_in_ready", in_ready, 0);
      end
      if (expq.size() > 4) chk("overfill", expq.size(), 4);
      if (in_valid && in_ready) expq.push_back(inq.pop_front());
      cyc++;
    end
    if (cyc >= budget) chk("stream_timeout", cyc, 0);
    if (mode == 1) chk("saw_full", saw_full, 1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    int l1, l4, l8;
    bit anyv;

    tbl[0]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0};
    tbl[1]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2]  = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[4]  = '{32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    tbl[5]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[6]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[7]  = '{32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    tbl[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[9]  = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    tbl[10] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0};
    tbl[11] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0};
    tbl[12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[13] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef PIPE_ADDER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif

    // Isolated vectors with latency checks.
    for (int i = 0; i < 14; i++) single(tbl[i]);
    repeat (10) @(negedge clk);

    // Same table back to back at full rate.
    for (int i = 0; i < 14; i++) inq.push_back(tbl[i]);
    run_stream(0, 100);
    repeat (10) @(negedge clk);

    // Back-pressure with 8 ops.
    for (int i = 0; i < 8; i++)
      inq.push_back(mk(32'h1000_0000 * i + i, 32'h0F0F_0F0F + i, i[0], 1'b0));
    run_stream(1, 200);
    repeat (10) @(negedge clk);

    // Random valid/ready against the arithmetic model.
    for (int i = 0; i < 1500; i++)
      inq.push_back(mk($urandom, $urandom, 1'($urandom), 1'($urandom)));
    run_stream(2, 20000);
    repeat (12) @(negedge clk);

    // Latency of all three depths on one op.
    l1 = 0; l4 = 0; l8 = 0;
    in_valid = 1'b1;
    drive(tbl[4]);
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (out_valid1 && l1 == 0) begin
        l1 = c;
        chk("s1_sum", sum1, tbl[4].s);
      end
      if (out_valid && l4 == 0) l4 = c;
      if (out_valid8 && l8 == 0) begin
        l8 = c;
        chk("s8_sum", sum8, tbl[4].s);
      end
      @(negedge clk);
    end
    chk("lat_s1", l1, 1);
    chk("lat_s4", l4, 4);
    chk("lat_s8", l8, 8);
    repeat (4) @(negedge clk);

    // Reset with ops in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      drive(tbl[i + 3]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_valid1", out_valid1, 0);
    chk("mid_rst_sum1", sum1, 0);
    chk("mid_rst_cout1", cout1, 0);
    chk("mid_rst_valid8", out_valid8, 0);
    chk("mid_rst_sum8", sum8, 0);
    chk("mid_rst_cout8", cout8, 0);
    rst = 1'b0;
    anyv = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid || out_valid1 || out_valid8) anyv = 1;
    end
    chk("no_stale_after_rst", anyv, 0);

    // After reset the pipe works again.
    single(tbl[10]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
